// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl: round-robin/fixed-priority arbiter sharing a 16-bit async SRAM between a fetch port and a load/store port
module sram_arbiter_ctrl #(
  parameter int WAIT_CYC = 1,
  parameter bit PRIO_B   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_req,
  input  logic [18:0] i_a_addr,
  output logic        o_a_ack,
  output logic [31:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [18:0] i_b_addr,
  input  logic [3:0]  i_b_be,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_ack,
  output logic [31:0] o_b_rdata,
  output logic        o_busy,
  output logic [17:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d, last_q, last_d, we_q, we_d;
  logic [16:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [15:0] lo_q, lo_d, dq_out_q, dq_out_d;
  logic [17:0] addr_q, addr_d;
  logic        ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d, lb_n_q, lb_n_d, ub_n_q, ub_n_d, dq_oe_q, dq_oe_d;
  logic        grant_b, phase_end, act, hi;
  logic [1:0]  bh;
  logic        unused_addr;
  assign unused_addr = ^{i_a_addr[1:0], i_b_addr[1:0]};
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      addr_q    <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      addr_q    <= addr_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      lb_n_q    <= lb_n_d;
      ub_n_q    <= ub_n_d;
    end
  end
  // write phases carry one extra hold cycle with WE_N released
  assign phase_end = cnt_q == (we_q ? 4'(WAIT_CYC) : 4'(WAIT_CYC - 1));
  assign grant_b   = i_b_req & (~i_a_req | PRIO_B | ~last_q);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 4'd1;
    sel_d     = sel_q;
    last_d    = last_q;
    we_d      = we_q;
    waddr_d   = waddr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_a_req || i_b_req) begin
          state_d = LO;
          sel_d   = grant_b;
          last_d  = grant_b;
          we_d    = grant_b & i_b_we;
          waddr_d = grant_b ? i_b_addr[18:2] : i_a_addr[18:2];
          be_d    = grant_b ? i_b_be : 4'hf;
          wdata_d = i_b_wdata;
        end
      end
      LO: if (phase_end) begin
        state_d = HI;
        cnt_d   = '0;
        lo_d    = io_SRAM_DQ;
      end
      HI: if (phase_end) begin
        state_d   = DONE;
        a_rdata_d = (!we_q && !sel_q) ? {io_SRAM_DQ, lo_q} : a_rdata_q;
        b_rdata_d = (!we_q &&  sel_q) ? {io_SRAM_DQ, lo_q} : b_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // pin values are computed from the next state so they are registered and stable per phase
  always_comb begin
    act      = state_d == LO || state_d == HI;
    hi       = state_d == HI;
    bh       = hi ? be_d[3:2] : be_d[1:0];
    ce_n_d   = ~act;
    oe_n_d   = ~(act & ~we_d);
    we_n_d   = ~(act & we_d & (cnt_d < 4'(WAIT_CYC)) & |bh);
    lb_n_d   = ~act | (we_d & ~bh[0]);
    ub_n_d   = ~act | (we_d & ~bh[1]);
    addr_d   = act ? {waddr_d, hi} : addr_q;
    dq_oe_d  = act & we_d;
    dq_out_d = hi ? wdata_d[31:16] : wdata_d[15:0];
    o_a_ack  = state_q == DONE && !sel_q;
    o_b_ack  = state_q == DONE && sel_q;
    o_busy   = state_q != IDLE;
  end
  assign io_SRAM_DQ  = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_a_rdata   = a_rdata_q;
  assign o_b_rdata   = b_rdata_q;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = lb_n_q;
  assign o_SRAM_UB_N = ub_n_q;
endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// tb_sram_arbiter_ctrl: three arbiter instances (RR W=1, PRIO_B W=1, RR W=3) each on a behavioural SRAM, checked by an ack scoreboard
module tb_sram_arbiter_ctrl;
  logic clk;
  logic [2:0] rst_n, a_req, b_req, b_we, tb_drv;
  logic [2:0][18:0] a_addr, b_addr;
  logic [2:0][3:0] b_be;
  logic [2:0][31:0] b_wdata;
  wire [2:0] a_ack, b_ack, busy, ce_n, we_n, oe_n, lb_n, ub_n;
  wire [2:0][31:0] a_rdata, b_rdata;
  wire [2:0][17:0] saddr;
  wire [2:0][15:0] dqv;
  typedef struct { logic pb; logic [31:0] data; logic cd; } exp_t;
  exp_t sbq [3][$];
  int checks = 0, failures = 0;
  logic [17:0] tr_addr [32];
  logic [15:0] tr_dq [32];
  logic tr_oe [32], tr_we [32], tr_lb [32], tr_ub [32], tr_ce [32];
  for (genvar g = 0; g < 3; g++) begin : gd
    wire [15:0] dq;
    logic [15:0] mem [1024];
    sram_arbiter_ctrl #(.WAIT_CYC(g == 2 ? 3 : 1), .PRIO_B(g == 1)) u (
      .i_clk(clk), .i_rst(rst_n[g]),
      .i_a_req(a_req[g]), .i_a_addr(a_addr[g]), .o_a_ack(a_ack[g]), .o_a_rdata(a_rdata[g]),
      .i_b_req(b_req[g]), .i_b_we(b_we[g]), .i_b_addr(b_addr[g]), .i_b_be(b_be[g]),
      .i_b_wdata(b_wdata[g]), .o_b_ack(b_ack[g]), .o_b_rdata(b_rdata[g]), .o_busy(busy[g]),
      .o_SRAM_ADDR(saddr[g]), .io_SRAM_DQ(dq), .o_SRAM_CE_N(ce_n[g]), .o_SRAM_WE_N(we_n[g]),
      .o_SRAM_OE_N(oe_n[g]), .o_SRAM_LB_N(lb_n[g]), .o_SRAM_UB_N(ub_n[g]));
    assign dq = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[saddr[g][9:0]] : 16'hzzzz;
    assign dq = tb_drv[g] ? 16'h0000 : 16'hzzzz;
    assign dqv[g] = dq;
    always @(posedge clk) if (!ce_n[g] && !we_n[g]) begin
      if (!lb_n[g]) mem[saddr[g][9:0]][7:0] <= dq[7:0];
      if (!ub_n[g]) mem[saddr[g][9:0]][15:8] <= dq[15:8];
    end
  end
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) if (a_ack[g] || b_ack[g]) begin
      checks++;
      assert (sbq[g].size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected_ack inst=%0d observed a_ack=%b b_ack=%b expected none", g, a_ack[g], b_ack[g]);
      end
      if (sbq[g].size() != 0) begin
        e = sbq[g].pop_front();
        chk($sformatf("sb_port_b_inst%0d", g), 32'(b_ack[g]), 32'(e.pb));
        chk($sformatf("sb_port_a_inst%0d", g), 32'(a_ack[g]), 32'(!e.pb));
        if (e.cd) chk($sformatf("sb_rdata_inst%0d", g), e.pb ? b_rdata[g] : a_rdata[g], e.data);
      end
    end
  end
  task automatic xact(input int g, input bit pb, input bit we, input logic [18:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] exp, input int lat, input string tag);
    int n;
    bit done;
    @(negedge clk);
    sbq[g].push_back('{pb: pb, data: exp, cd: !we});
    if (pb) begin
      b_req[g] = 1'b1; b_we[g] = we; b_addr[g] = addr; b_be[g] = be; b_wdata[g] = wd;
    end else begin
      a_req[g] = 1'b1; a_addr[g] = addr;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (n < 32) begin
        tr_addr[n] = saddr[g]; tr_dq[n] = dqv[g]; tr_oe[n] = oe_n[g];
        tr_we[n] = we_n[g]; tr_lb[n] = lb_n[g]; tr_ub[n] = ub_n[g]; tr_ce[n] = ce_n[g];
      end
      done = pb ? b_ack[g] : a_ack[g];
    end
    a_req[g] = 1'b0;
    b_req[g] = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(lat));
  endtask
  initial begin
    int n, k;
    rst_n = '0; a_req = '0; b_req = '0; b_we = '0; tb_drv = 3'b111;
    a_addr = '0; b_addr = '0; b_be = '0; b_wdata = '0;
    gd[0].mem[10'h008] = 16'h1234; gd[0].mem[10'h009] = 16'hABCD;
    gd[0].mem[10'h100] = 16'h1111; gd[0].mem[10'h101] = 16'hAAAA;
    gd[0].mem[10'h180] = 16'h2222; gd[0].mem[10'h181] = 16'hBBBB;
    gd[1].mem[10'h100] = 16'h3333; gd[1].mem[10'h101] = 16'hCCCC;
    gd[1].mem[10'h180] = 16'h4444; gd[1].mem[10'h181] = 16'hDDDD;
    gd[2].mem[10'h040] = 16'h5678; gd[2].mem[10'h041] = 16'h9ABC;
    #12;
    chk("rst_strobes", 32'({ce_n[0], we_n[0], oe_n[0], lb_n[0], ub_n[0]}), 32'h1f);
    chk("rst_addr", 32'(saddr[0]), 32'h0);
    chk("rst_dq_released", 32'(dqv[0]), 32'h0);
    chk("rst_ack_busy", 32'({a_ack[0], b_ack[0], busy[0]}), 32'h0);
    chk("rst_rdata", a_rdata[0] | b_rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 3'b111; tb_drv = '0;
    xact(0, 1'b0, 1'b0, 19'h00010, 4'hf, 32'h0, 32'hABCD1234, 3, "a_read");
    chk("a_read_c1_addr", 32'(tr_addr[1]), 32'h8);
    chk("a_read_c2_addr", 32'(tr_addr[2]), 32'h9);
    chk("a_read_c1c2_oe", 32'({tr_oe[1], tr_oe[2], tr_we[1], tr_we[2]}), 32'h3);
    chk("a_read_c3_idle_pins", 32'({tr_oe[3], tr_ce[3]}), 32'h3);
    xact(0, 1'b1, 1'b1, 19'h00020, 4'hf, 32'hDEADBEEF, 32'h0, 5, "b_write");
    chk("b_write_lo_addr", 32'({tr_addr[1], tr_addr[2]}), {14'h0, 18'h10, 18'h10} >> 18 == 0 ? 32'h0 : 32'({18'h10, 18'h10}));
    chk("b_write_hi_addr", 32'(tr_addr[3]), 32'h11);
    chk("b_write_lo_dq", 32'({tr_dq[1], tr_dq[2]}), 32'hBEEFBEEF);
    chk("b_write_hi_dq", 32'({tr_dq[3], tr_dq[4]}), 32'hDEADDEAD);
    chk("b_write_we_pulses", 32'({tr_we[1], tr_we[2], tr_we[3], tr_we[4], tr_oe[1]}), 32'b01011);
    xact(0, 1'b1, 1'b0, 19'h00020, 4'h0, 32'h0, 32'hDEADBEEF, 3, "b_readback");
    xact(0, 1'b1, 1'b1, 19'h00020, 4'b0100, 32'h00770000, 32'h0, 5, "b_write_byte2");
    chk("byte2_lo_no_we", 32'({tr_we[1], tr_we[2]}), 32'h3);
    chk("byte2_hi_strobes", 32'({tr_we[3], tr_lb[3], tr_ub[3]}), 32'b001);
    chk("byte2_mem_hi", 32'(gd[0].mem[10'h011]), 32'hDE77);
    xact(0, 1'b0, 1'b0, 19'h00020, 4'hf, 32'h0, 32'hDE77BEEF, 3, "byte2_readback");
    @(negedge clk);
    b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 19'h00040; b_be[0] = 4'hf; b_wdata[0] = 32'h11223344;
    repeat (3) @(negedge clk);
    chk("midwrite_hi_we_low", 32'({we_n[0], busy[0], saddr[0]}), 32'({1'b0, 1'b1, 18'h21}));
    #1;
    rst_n[0] = 1'b0; tb_drv[0] = 1'b1;
    #1;
    chk("midwrite_rst_strobes", 32'({we_n[0], ce_n[0], oe_n[0]}), 32'h7);
    chk("midwrite_rst_dq_released", 32'(dqv[0]), 32'h0);
    chk("midwrite_rst_busy_ack", 32'({busy[0], a_ack[0], b_ack[0]}), 32'h0);
    chk("midwrite_rst_rdata", a_rdata[0] | b_rdata[0], 32'h0);
    b_req[0] = 1'b0;
    @(negedge clk);
    chk("midwrite_rst_no_ack", 32'({a_ack[0], b_ack[0], busy[0]}), 32'h0);
    rst_n[0] = 1'b1; tb_drv[0] = 1'b0;
    xact(0, 1'b0, 1'b0, 19'h00010, 4'hf, 32'h0, 32'hABCD1234, 3, "post_rst_a_read");
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sbq[0].push_back('{pb: 1'b1, data: 32'hBBBB2222, cd: 1'b1});
      sbq[0].push_back('{pb: 1'b0, data: 32'hAAAA1111, cd: 1'b1});
    end
    @(negedge clk);
    a_req[0] = 1'b1; a_addr[0] = 19'h00200; b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 19'h00300;
    n = 0; k = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (a_ack[0] || b_ack[0]) k++;
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    chk("rr_total_cycles", 32'(n), 32'd15);
    for (int i = 0; i < 3; i++) sbq[1].push_back('{pb: 1'b1, data: 32'hDDDD4444, cd: 1'b1});
    sbq[1].push_back('{pb: 1'b0, data: 32'hCCCC3333, cd: 1'b1});
    @(negedge clk);
    a_req[1] = 1'b1; a_addr[1] = 19'h00200; b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 19'h00300;
    n = 0; k = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (a_ack[1] || b_ack[1]) begin
        k++;
        if (k == 3) b_req[1] = 1'b0;
      end
    end
    a_req[1] = 1'b0; b_req[1] = 1'b0;
    chk("prio_total_cycles", 32'(n), 32'd15);
    xact(1, 1'b1, 1'b0, 19'h00300, 4'h0, 32'h0, 32'hDDDD4444, 3, "prio_b_alone");
    xact(1, 1'b0, 1'b0, 19'h00200, 4'hf, 32'h0, 32'hCCCC3333, 3, "prio_a_after_b");
    xact(2, 1'b0, 1'b0, 19'h00083, 4'hf, 32'h0, 32'h9ABC5678, 7, "w3_read_a11");
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("w3_c%0d_oe", c), 32'(tr_oe[c]), 32'h0);
      chk($sformatf("w3_c%0d_addr", c), 32'(tr_addr[c]), c <= 3 ? 32'h40 : 32'h41);
    end
    chk("w3_c7_oe", 32'(tr_oe[7]), 32'h1);
    xact(2, 1'b0, 1'b0, 19'h00080, 4'hf, 32'h0, 32'h9ABC5678, 7, "w3_read_a00");
    xact(2, 1'b1, 1'b1, 19'h00081, 4'hf, 32'hCAFEF00D, 32'h0, 9, "w3_write");
    chk("w3_write_we", 32'({tr_we[1], tr_we[3], tr_we[4], tr_we[5], tr_we[8]}), 32'b00101);
    xact(2, 1'b1, 1'b0, 19'h00080, 4'h0, 32'h0, 32'hCAFEF00D, 7, "w3_readback");
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("sb_drained_inst%0d", g), 32'(sbq[g].size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Shares the single external 16-bit asynchronous SRAM between two pipeline requesters: port A (instruction fetch, read-only) and port B (load/store unit, read/write with byte enables).
- Each 32-bit word access is split into two halfword SRAM phases, low half first.
- Arbitration is round-robin or fixed priority, selected by parameter. Sits between the pipeline core and the SRAM pins.

Parameters:
- WAIT_CYC, 1, clock cycles per halfword access phase; legal range 1..15.
- PRIO_B, 0, 0 = round-robin; 1 = port B always wins ties.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_a_req  in  1  port A read request (level)
- i_a_addr  in  19  port A byte address; [1:0] ignored
- o_a_ack  out  1  port A completion pulse
- o_a_rdata  out  32  port A read word
- i_b_req  in  1  port B request (level)
- i_b_we  in  1  port B: 1 = write, 0 = read
- i_b_addr  in  19  port B byte address; [1:0] ignored
- i_b_be  in  4  port B write byte enables
- i_b_wdata  in  32  port B write word
- o_b_ack  out  1  port B completion pulse
- o_b_rdata  out  32  port B read word
- o_busy  out  1  high in any state other than IDLE
- o_SRAM_ADDR  out  18  halfword address
- io_SRAM_DQ  inout  16  SRAM data; hi-Z except during write phases
- o_SRAM_CE_N, o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low SRAM strobes

Behaviour:
- Reset (i_rst=0, asynchronous, effective mid-transfer):
  - State = IDLE.
  - All SRAM strobes = 1, o_SRAM_ADDR = 0, DQ hi-Z.
  - Acks = 0, o_busy = 0, both rdata = 0, last-grant = A.
  - No partial-write recovery is attempted.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - On a clock edge with any req high: latch the winner's address, we, be and wdata; go to LO.
  - Tie, PRIO_B=0: grant the port not granted last.
  - Tie, PRIO_B=1: grant B.
  - Only A requesting: granted even if B granted last.
- Address mapping:
  - LO phase: o_SRAM_ADDR = {addr[18:2], 0}.
  - HI phase: o_SRAM_ADDR = {addr[18:2], 1}.
  - All SRAM outputs are registered and stable for the whole phase.
- Read phase:
  - Lasts WAIT_CYC cycles with CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0.
  - DQ is sampled on the edge ending the phase: LO fills rdata[15:0], HI fills rdata[31:16].
- Write phase:
  - Lasts WAIT_CYC+1 cycles with CE_N=0 and OE_N=1.
  - DQ driven with wdata[15:0] (LO) or wdata[31:16] (HI) for the full phase.
  - WE_N=0 for the first WAIT_CYC cycles, 1 in the final (hold) cycle.
  - LO: LB_N=~be[0], UB_N=~be[1]. HI: LB_N=~be[2], UB_N=~be[3].
  - A half with be=00 still takes its cycles but WE_N stays 1.
- DONE:
  - One cycle; the granted port's ack = 1, all SRAM strobes = 1.
  - o_x_rdata is updated for reads and held until that port's next read ack. Writes leave rdata unchanged.
- Handshake:
  - Requester holds req, addr, we, be and wdata stable until ack.
  - The transfer completes on the edge where ack=1. Req high in the cycle after ack is a new request.
  - Deasserting req before ack is illegal; the transfer completes regardless.
- Latency from IDLE request edge to ack cycle:
  - Read: 2*WAIT_CYC+1 cycles.
  - Write: 2*WAIT_CYC+3 cycles.
  - Back-to-back occupancy is one extra IDLE cycle.
- Last-grant updates only on grant.
- Non-granted req is held pending with no ack and no timeout.

Test Plan:
- WAIT_CYC=1; A read 0x00010 with SRAM[0x8]=0x1234, [0x9]=0xABCD -> ADDR 0x8 then 0x9, OE_N=0 two cycles, o_a_ack in cycle 3, o_a_rdata=0xABCD1234.
- B write 0x00020, be=1111, wdata=0xDEADBEEF -> ADDR 0x10 DQ 0xBEEF, then 0x11 DQ 0xDEAD; WE_N low 1 cycle each; ack cycle 5; readback equals.
- B write be=0100, wdata=0x00770000 to 0x20 -> LO phase WE_N stays 1; HI phase LB_N=0, UB_N=1; only byte 2 = 0x77, other bytes unchanged.
- A and B request together repeatedly, PRIO_B=0 -> grants B,A,B,A after reset. Same with PRIO_B=1 -> B always first; A served only when B idle.
- Reset pulled low mid-HI write phase -> same cycle: WE_N=CE_N=1, DQ hi-Z, o_busy=0, no ack. After release, a new A read completes normally.
- WAIT_CYC=3 read -> OE_N low 3 cycles per phase, ack at cycle 7. Address with [1:0]=11 maps identically to [1:0]=00.
